cfu_reorder_buf: RTL

In-order request/response adapter between a CPU-side issue port and a `CFU`-style core that may complete requests out of order. It allocates a slot and a `req_id` for every issued request, passes the request through to the CFU combinationally, and collects responses by `resp_id`. It then returns results to the CPU strictly in issue order. It sits directly upstream of, and consumes responses from, the general CFU interface.

---
 rtl/cfu_reorder_buf_if.sv | 58 +++++
 rtl/cfu_reorder_buf.sv | 93 +++++++++
 2 files changed

// File: rtl/cfu_reorder_buf_if.sv
// Bundles the CPU-side and CFU-side handshakes of the reorder buffer.
// The slave modport is the buffer's view; master is the surrounding CPU/CFU environment.
interface cfu_reorder_buf_if #(
  parameter int CFU_FUNCTION_ID_W = 16,
  parameter int CFU_REQ_RESP_ID_W = 6,
  parameter int CFU_REQ_INPUTS    = 2,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = CFU_REQ_DATA_W,
  parameter int CFU_ERROR_ID_W    = CFU_RESP_DATA_W
) ();

  logic                                     cpu_req_valid;
  logic                                     cpu_req_ready;
  logic [CFU_FUNCTION_ID_W-1:0]             cpu_req_function_id;
  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0] cpu_req_data;

  logic                                     cfu_req_valid;
  logic                                     cfu_req_ready;
  logic [CFU_REQ_RESP_ID_W-1:0]             cfu_req_id;
  logic [CFU_FUNCTION_ID_W-1:0]             cfu_req_function_id;
  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0] cfu_req_data;

  logic                                     cfu_resp_valid;
  logic                                     cfu_resp_ready;
  logic [CFU_REQ_RESP_ID_W-1:0]             cfu_resp_id;
  logic [CFU_RESP_DATA_W-1:0]               cfu_resp_data;
  logic                                     cfu_resp_ok;
  logic [CFU_ERROR_ID_W-1:0]                cfu_resp_error_id;

  logic                                     cpu_resp_valid;
  logic                                     cpu_resp_ready;
  logic [CFU_RESP_DATA_W-1:0]               cpu_resp_data;
  logic                                     cpu_resp_ok;
  logic [CFU_ERROR_ID_W-1:0]                cpu_resp_error_id;

  modport slave (
    input  cpu_req_valid, cpu_req_function_id, cpu_req_data,
    output cpu_req_ready,
    output cfu_req_valid, cfu_req_id, cfu_req_function_id, cfu_req_data,
    input  cfu_req_ready,
    input  cfu_resp_valid, cfu_resp_id, cfu_resp_data, cfu_resp_ok, cfu_resp_error_id,
    output cfu_resp_ready,
    output cpu_resp_valid, cpu_resp_data, cpu_resp_ok, cpu_resp_error_id,
    input  cpu_resp_ready
  );

  modport master (
    output cpu_req_valid, cpu_req_function_id, cpu_req_data,
    input  cpu_req_ready,
    input  cfu_req_valid, cfu_req_id, cfu_req_function_id, cfu_req_data,
    output cfu_req_ready,
    output cfu_resp_valid, cfu_resp_id, cfu_resp_data, cfu_resp_ok, cfu_resp_error_id,
    input  cfu_resp_ready,
    input  cpu_resp_valid, cpu_resp_data, cpu_resp_ok, cpu_resp_error_id,
    output cpu_resp_ready
  );

endinterface

// File: rtl/cfu_reorder_buf.sv
// In-order adapter in front of an out-of-order CFU: tags each request with a slot id,
// collects responses by id and releases them to the CPU strictly in issue order.
module cfu_reorder_buf #(
  parameter int CFU_FUNCTION_ID_W = 16,
  parameter int CFU_REQ_RESP_ID_W = 6,
  parameter int CFU_REQ_INPUTS    = 2,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = CFU_REQ_DATA_W,
  parameter int CFU_ERROR_ID_W    = CFU_RESP_DATA_W,
  parameter int DEPTH             = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  cfu_reorder_buf_if.slave         bus,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     spurious
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]           head, tail;
  logic [IDX_W-1:0]           head_idx, tail_idx, rsp_idx, rsp_off;
  logic [DEPTH-1:0]           done;
  logic [CFU_RESP_DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]           slot_ok;
  logic [CFU_ERROR_ID_W-1:0]  slot_err  [DEPTH];

  logic full, empty, issue, collect, deliver, in_range, allocated;

  assign head_idx    = head[IDX_W-1:0];
  assign tail_idx    = tail[IDX_W-1:0];
  assign empty       = (head == tail);
  assign full        = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
  assign outstanding = tail - head;

  // Request path is purely combinational; the slot id is simply the tail index.
  assign bus.cfu_req_valid       = bus.cpu_req_valid && !full;
  assign bus.cpu_req_ready       = bus.cfu_req_ready && !full;
  assign bus.cfu_req_function_id = bus.cpu_req_function_id;
  assign bus.cfu_req_data        = bus.cpu_req_data;
  assign bus.cfu_req_id          = CFU_REQ_RESP_ID_W'(tail_idx);
  assign issue                   = bus.cpu_req_valid && bus.cfu_req_ready && !full;

  // A response is legal only for an allocated, not-yet-completed slot; distance from
  // head (mod DEPTH) below the occupancy identifies allocated slots, including when full.
  assign rsp_idx   = bus.cfu_resp_id[IDX_W-1:0];
  assign rsp_off   = rsp_idx - head_idx;
  assign in_range  = 32'(bus.cfu_resp_id) < 32'(DEPTH);
  assign allocated = {1'b0, rsp_off} < outstanding;
  assign collect   = bus.cfu_resp_valid && in_range && allocated && !done[rsp_idx];

  assign bus.cfu_resp_ready = 1'b1;

  assign bus.cpu_resp_valid    = !empty && done[head_idx];
  assign bus.cpu_resp_data     = slot_data[head_idx];
  assign bus.cpu_resp_ok       = slot_ok[head_idx];
  assign bus.cpu_resp_error_id = slot_err[head_idx];
  assign deliver               = bus.cpu_resp_valid && bus.cpu_resp_ready;

  // Control state: pointers, completion flags and the drop indicator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      done     <= '0;
      spurious <= 1'b0;
    end else begin
      if (issue) begin
        tail           <= tail + PTR_W'(1);
        done[tail_idx] <= 1'b0;
      end
      if (deliver) begin
        head           <= head + PTR_W'(1);
        done[head_idx] <= 1'b0;
      end
      if (collect) begin
        done[rsp_idx] <= 1'b1;
      end
      spurious <= bus.cfu_resp_valid && !collect;
    end
  end

  // Slot payload is only meaningful once done is set, so it carries no reset.
  always_ff @(posedge clock) begin
    if (collect) begin
      slot_data[rsp_idx] <= bus.cfu_resp_data;
      slot_ok[rsp_idx]   <= bus.cfu_resp_ok;
      slot_err[rsp_idx]  <= bus.cfu_resp_error_id;
    end
  end

endmodule
